// File: rtl/branch_fetch_ctrl.sv
// branch_fetch_ctrl: hardwired control sequencer for the instruction fetch
// cycle and the conditional-branch class (zr/nz/pl/mi/always/never).
// Owns the CON flip-flop and a saturating taken-branch counter.
//
// Parameters: DATA_WIDTH (>= 24), OP_BRANCH, ALU_ADD, COUNT_WIDTH
// Ports:
//   Clock, clear (async, active-low)
//   start       - begin one fetch+execute, only looked at in IDLE
//   mem_ready   - memory read complete, looked at in T1/T1W
//   ir_in       - IR contents (opcode/Ra/C2/constant)
//   bus_in      - bus value, R[a] during T3
//   PCout..Cout - datapath strobes (Moore, from registered state)
//   alu_op      - ALU opcode, ALU_ADD in T5 only
//   con_flag    - CON flip-flop
//   done        - one-cycle retire pulse
//   op_err      - one-cycle pulse in T3 when opcode is not a branch
//   taken_count - saturating count of taken branches
//
// state | meaning
// IDLE  | waiting for start
// T0    | PC to MAR, PC+1 into Z
// T1    | Z to PC, start memory read
// T1W   | memory read stretched until mem_ready
// T2    | MDR to IR
// T3    | R[a] on bus, latch branch condition into CON (or flag bad opcode)
// T4    | taken: PC into Y; not taken: idle cycle before DONE
// T5    | C sign-extended + Y into Z
// T6    | Z to PC, count taken branch
// DONE  | retire pulse
module branch_fetch_ctrl #(
   parameter int         DATA_WIDTH  = 32,
   parameter logic [4:0] OP_BRANCH   = 5'b10010,
   parameter logic [4:0] ALU_ADD     = 5'b00011,
   parameter int         COUNT_WIDTH = 16
) (
   input  logic                   Clock,
   input  logic                   clear,
   input  logic                   start,
   input  logic                   mem_ready,
   input  logic [DATA_WIDTH-1:0]  ir_in,
   input  logic [DATA_WIDTH-1:0]  bus_in,
   output logic                   PCout,
   output logic                   MARin,
   output logic                   IncPC,
   output logic                   Zin,
   output logic                   Zlowout,
   output logic                   PCin,
   output logic                   Read,
   output logic                   MDRin,
   output logic                   MDRout,
   output logic                   IRin,
   output logic                   Gra,
   output logic                   Rout,
   output logic                   CONin,
   output logic                   Yin,
   output logic                   Cout,
   output logic [4:0]             alu_op,
   output logic                   con_flag,
   output logic                   done,
   output logic                   op_err,
   output logic [COUNT_WIDTH-1:0] taken_count
);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
   } state_t;

   state_t state_q, state_nxt;
   logic   con_ff;
   logic   cond_met;

   logic [4:0] opcode;
   logic [2:0] c2_sel;
   logic       is_branch;
   logic       unused_ir;

   assign opcode    = ir_in[DATA_WIDTH-1 -: 5];
   assign c2_sel    = ir_in[DATA_WIDTH-11 -: 3];
   assign is_branch = (opcode == OP_BRANCH);
   // Ra selection happens in the register file via Gra; C2[3] and the
   // constant field are not decoded here.
   assign unused_ir = ^{ir_in[DATA_WIDTH-6 -: 5], ir_in[DATA_WIDTH-14:0]};

   always_comb begin
      case (c2_sel)
         3'b000:  cond_met = (bus_in == '0);
         3'b001:  cond_met = (bus_in != '0);
         3'b010:  cond_met = ~bus_in[DATA_WIDTH-1];
         3'b011:  cond_met = bus_in[DATA_WIDTH-1];
         3'b100:  cond_met = 1'b1;
         default: cond_met = 1'b0;
      endcase
   end

   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         state_q     <= S_IDLE;
         con_ff      <= 1'b0;
         taken_count <= '0;
      end else begin
         state_q <= state_nxt;
         if (state_q == S_T3 && is_branch)
            con_ff <= cond_met;
         if (state_q == S_T6 && taken_count != '1)
            taken_count <= taken_count + COUNT_WIDTH'(1);
      end
   end

   always_comb begin
      state_nxt = state_q;
      PCout   = 1'b0;
      MARin   = 1'b0;
      IncPC   = 1'b0;
      Zin     = 1'b0;
      Zlowout = 1'b0;
      PCin    = 1'b0;
      Read    = 1'b0;
      MDRin   = 1'b0;
      MDRout  = 1'b0;
      IRin    = 1'b0;
      Gra     = 1'b0;
      Rout    = 1'b0;
      CONin   = 1'b0;
      Yin     = 1'b0;
      Cout    = 1'b0;
      alu_op  = 5'd0;
      done    = 1'b0;
      op_err  = 1'b0;
      case (state_q)
         S_IDLE: if (start) state_nxt = S_T0;
         S_T0: begin
            PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            state_nxt = S_T1;
         end
         S_T1: begin
            Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            state_nxt = mem_ready ? S_T2 : S_T1W;
         end
         // PC was already loaded in T1; only the read is stretched.
         S_T1W: begin
            Read = 1'b1; MDRin = 1'b1;
            if (mem_ready) state_nxt = S_T2;
         end
         S_T2: begin
            MDRout = 1'b1; IRin = 1'b1;
            state_nxt = S_T3;
         end
         S_T3: begin
            if (is_branch) begin
               Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
               state_nxt = S_T4;
            end else begin
               op_err    = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_T4: begin
            if (con_ff) begin
               PCout = 1'b1; Yin = 1'b1;
               state_nxt = S_T5;
            end else begin
               state_nxt = S_DONE;
            end
         end
         S_T5: begin
            Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD;
            state_nxt = S_T6;
         end
         S_T6: begin
            Zlowout = 1'b1; PCin = 1'b1;
            state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign con_flag = con_ff;

endmodule

// File: tb/tb_branch_fetch_ctrl.sv
module tb_branch_fetch_ctrl;

   logic        Clock = 1'b0;
   logic        clear, start, mem_ready;
   logic [31:0] ir_in, bus_in;

   logic [14:0] strb;
   logic [4:0]  alu_op;
   logic        con_flag, done, op_err;
   logic [15:0] taken_count;

   logic [14:0] s_strb;
   logic [4:0]  s_alu_op;
   logic        s_con_flag, s_done, s_op_err;
   logic [1:0]  s_taken_count;

   int n_checks = 0;
   int n_err    = 0;

   int unsigned model_taken;
   bit          model_con;

   always #5 Clock = ~Clock;

   branch_fetch_ctrl dut (
      .Clock(Clock), .clear(clear), .start(start), .mem_ready(mem_ready),
      .ir_in(ir_in), .bus_in(bus_in),
      .PCout(strb[14]), .MARin(strb[13]), .IncPC(strb[12]), .Zin(strb[11]),
      .Zlowout(strb[10]), .PCin(strb[9]), .Read(strb[8]), .MDRin(strb[7]),
      .MDRout(strb[6]), .IRin(strb[5]), .Gra(strb[4]), .Rout(strb[3]),
      .CONin(strb[2]), .Yin(strb[1]), .Cout(strb[0]),
      .alu_op(alu_op), .con_flag(con_flag), .done(done), .op_err(op_err),
      .taken_count(taken_count)
   );

   branch_fetch_ctrl #(.COUNT_WIDTH(2)) dut_sat (
      .Clock(Clock), .clear(clear), .start(start), .mem_ready(mem_ready),
      .ir_in(ir_in), .bus_in(bus_in),
      .PCout(s_strb[14]), .MARin(s_strb[13]), .IncPC(s_strb[12]), .Zin(s_strb[11]),
      .Zlowout(s_strb[10]), .PCin(s_strb[9]), .Read(s_strb[8]), .MDRin(s_strb[7]),
      .MDRout(s_strb[6]), .IRin(s_strb[5]), .Gra(s_strb[4]), .Rout(s_strb[3]),
      .CONin(s_strb[2]), .Yin(s_strb[1]), .Cout(s_strb[0]),
      .alu_op(s_alu_op), .con_flag(s_con_flag), .done(s_done), .op_err(s_op_err),
      .taken_count(s_taken_count)
   );

   localparam logic [14:0] B_PCOUT   = 15'h4000;
   localparam logic [14:0] B_MARIN   = 15'h2000;
   localparam logic [14:0] B_INCPC   = 15'h1000;
   localparam logic [14:0] B_ZIN     = 15'h0800;
   localparam logic [14:0] B_ZLOWOUT = 15'h0400;
   localparam logic [14:0] B_PCIN    = 15'h0200;
   localparam logic [14:0] B_READ    = 15'h0100;
   localparam logic [14:0] B_MDRIN   = 15'h0080;
   localparam logic [14:0] B_MDROUT  = 15'h0040;
   localparam logic [14:0] B_IRIN    = 15'h0020;
   localparam logic [14:0] B_GRA     = 15'h0010;
   localparam logic [14:0] B_ROUT    = 15'h0008;
   localparam logic [14:0] B_CONIN   = 15'h0004;
   localparam logic [14:0] B_YIN     = 15'h0002;
   localparam logic [14:0] B_COUT    = 15'h0001;

   typedef struct {
      logic [31:0] ir;
      logic [31:0] bus;
      int          wt;
      bit          exp_con;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [21:0] mk(logic [14:0] s, logic [4:0] a, logic d, logic e);
      return {s, a, d, e};
   endfunction

   // Branch condition straight from the instruction-set definition.
   function automatic bit cond_of(logic [31:0] ir, logic [31:0] b);
      int sel;
      sel = int'(ir[21:19]);
      if (sel == 0) return b == 0;
      if (sel == 1) return b != 0;
      if (sel == 2) return $signed(b) >= 0;
      if (sel == 3) return $signed(b) < 0;
      if (sel == 4) return 1'b1;
      return 1'b0;
   endfunction

   function automatic longint sat(int unsigned v, int unsigned maxv);
      return (v > maxv) ? longint'(maxv) : longint'(v);
   endfunction

   // Called right after a falling edge. Drives one instruction and compares
   // every cycle from k+1 through the IDLE cycle that follows it.
   task automatic run_instr(input logic [31:0] ir, input logic [31:0] b, input int wt,
                            input string tag);
      logic [21:0] exp_q[$];
      logic [21:0] got;
      bit is_br, taken;
      int t3;
      is_br = (ir[31:27] == 5'b10010);
      taken = is_br && cond_of(ir, b);
      t3    = 4 + wt;

      exp_q.push_back(mk(B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 5'd0, 1'b0, 1'b0));
      exp_q.push_back(mk(B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN, 5'd0, 1'b0, 1'b0));
      for (int w = 0; w < wt; w++)
         exp_q.push_back(mk(B_READ | B_MDRIN, 5'd0, 1'b0, 1'b0));
      exp_q.push_back(mk(B_MDROUT | B_IRIN, 5'd0, 1'b0, 1'b0));
      if (!is_br) begin
         exp_q.push_back(mk(15'd0, 5'd0, 1'b0, 1'b1));
      end else begin
         exp_q.push_back(mk(B_GRA | B_ROUT | B_CONIN, 5'd0, 1'b0, 1'b0));
         if (taken) begin
            exp_q.push_back(mk(B_PCOUT | B_YIN, 5'd0, 1'b0, 1'b0));
            exp_q.push_back(mk(B_COUT | B_ZIN, 5'b00011, 1'b0, 1'b0));
            exp_q.push_back(mk(B_ZLOWOUT | B_PCIN, 5'd0, 1'b0, 1'b0));
         end else begin
            exp_q.push_back(mk(15'd0, 5'd0, 1'b0, 1'b0));
         end
         exp_q.push_back(mk(15'd0, 5'd0, 1'b1, 1'b0));
      end
      exp_q.push_back(mk(15'd0, 5'd0, 1'b0, 1'b0));

      ir_in     = ir;
      bus_in    = ~b;
      mem_ready = 1'b1;
      start     = 1'b1;
      for (int i = 1; i <= exp_q.size(); i++) begin
         @(negedge Clock);
         got = {strb, alu_op, done, op_err};
         check($sformatf("%s cyc%0d", tag, i), 64'(got), 64'(exp_q[i-1]));
         start     = 1'b0;
         mem_ready = !(i >= 2 && i < 2 + wt);
         // Correct operand only in the T3 cycle; its complement elsewhere
         // exposes a condition latched on the wrong edge.
         bus_in    = (i == t3) ? b : ~b;
      end
      mem_ready = 1'b1;

      if (is_br) model_con = cond_of(ir, b);
      if (taken) model_taken++;
      check({tag, " con_flag"}, 64'(con_flag), 64'(model_con));
      check({tag, " taken_count"}, 64'(taken_count), 64'(sat(model_taken, 65535)));
      check({tag, " sat_count"}, 64'(s_taken_count), 64'(sat(model_taken, 3)));
   endtask

   task automatic do_reset();
      @(negedge Clock);
      clear = 1'b0;
      #1;
      check("reset outputs", 64'({strb, alu_op, done, op_err, con_flag}), 64'(0));
      check("reset count", 64'(taken_count), 64'(0));
      @(negedge Clock);
      clear = 1'b1;
      model_taken = 0;
      model_con   = 1'b0;
   endtask

   initial begin
      logic [31:0] rir, rbus;
      clear = 1'b0; start = 1'b0; mem_ready = 1'b1;
      ir_in = '0; bus_in = '0;
      model_taken = 0; model_con = 1'b0;

      vecs[0] = '{32'h91000023, 32'h00000000, 0, 1'b1};
      vecs[1] = '{32'h91080023, 32'h00000000, 0, 1'b0};
      vecs[2] = '{32'h91180023, 32'h80000000, 0, 1'b1};
      vecs[3] = '{32'h91100023, 32'h80000000, 0, 1'b0};
      vecs[4] = '{32'h91100023, 32'h00000000, 0, 1'b1};
      vecs[5] = '{32'h91000023, 32'h00000000, 3, 1'b1};
      vecs[6] = '{32'h18000000, 32'h00000005, 0, 1'b1};
      vecs[7] = '{32'h91200023, 32'h00000007, 1, 1'b1};
      vecs[8] = '{32'h91280023, 32'h00000000, 2, 1'b0};
      vecs[9] = '{32'h91380023, 32'h80000000, 0, 1'b0};

      #1;
      check("async reset at t0", 64'({strb, alu_op, done, op_err, con_flag}), 64'(0));
      repeat (2) @(negedge Clock);
      clear = 1'b1;

      foreach (vecs[v]) begin
         run_instr(vecs[v].ir, vecs[v].bus, vecs[v].wt, $sformatf("vec%0d", v));
         check($sformatf("vec%0d table con", v), 64'(con_flag), 64'(vecs[v].exp_con));
      end

      for (int r = 0; r < 40; r++) begin
         rir = $urandom;
         if ($urandom_range(0, 9) < 8) rir[31:27] = 5'b10010;
         case ($urandom_range(0, 2))
            0:       rbus = 32'h0;
            1:       rbus = 32'h80000000 | $urandom;
            default: rbus = $urandom & 32'h7fffffff;
         endcase
         run_instr(rir, rbus, int'($urandom_range(0, 3)), $sformatf("rnd%0d", r));
      end

      // Asynchronous clear in the middle of T5.
      do_reset();
      ir_in = 32'h91000023; bus_in = 32'h0; mem_ready = 1'b1; start = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(negedge Clock);
         start = 1'b0;
      end
      check("T5 alu_op before clear", 64'(alu_op), 64'(5'b00011));
      #2 clear = 1'b0;
      #1;
      check("clear mid-T5 outputs", 64'({strb, alu_op, done, op_err, con_flag}), 64'(0));
      check("clear mid-T5 count", 64'({taken_count, s_taken_count}), 64'(0));
      #1 clear = 1'b1;
      @(negedge Clock);
      check("idle after clear", 64'({strb, alu_op, done, op_err}), 64'(0));
      model_taken = 0; model_con = 1'b0;

      // Saturation of the 2-bit counter instance.
      for (int s = 0; s < 5; s++)
         run_instr(32'h91000023, 32'h0, 0, $sformatf("sat%0d", s));
      check("sat final 2-bit", 64'(s_taken_count), 64'(2'b11));
      check("sat final 16-bit", 64'(taken_count), 64'(5));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
